// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the EX-stage multiply/divide unit.
package mips_pkg;

    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t;

    typedef enum logic [2:0] {IDLE, RUN, FIX, DONE} md_state_t;

    localparam int MD_CYCLES = 32;

endpackage

// File: rtl/mips_muldiv_step.sv
// Single iteration of the multiply/divide datapath (purely combinational).
// Multiply: acc = {partial product, remaining multiplier bits}.
// Divide:   acc = {partial remainder, remaining dividend / quotient bits}.
module mips_muldiv_step
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_CYCLES
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;

    // Shift-add for multiply, restore-subtract for divide; trial[WIDTH] set means borrow.
    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        if (!is_div) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
            acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {acc[2*WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operates on magnitudes and applies sign correction in the FIX state.
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state, state_nx;
    md_op_t             op_in;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
    logic [WIDTH-1:0]   opnd, a_raw, a_abs, b_abs, q_fix, r_fix;
    logic               is_div, neg_q, neg_r, div_zero;
    logic               op_div, signed_op, sa, sb, b_zero;

    assign op_in     = md_op_t'(op);
    assign op_div    = (op_in == MD_DIV) || (op_in == MD_DIVU);
    assign signed_op = (op_in == MD_MULT) || (op_in == MD_DIV);
    assign sa        = signed_op & a[WIDTH-1];
    assign sb        = signed_op & b[WIDTH-1];
    assign a_abs     = sa ? -a : a;
    assign b_abs     = sb ? -b : b;
    assign b_zero    = (b == '0);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .operand  (opnd),
        .is_div   (is_div),
        .acc_next (acc_step)
    );

    // Sign correction of the magnitude result; the remainder follows the dividend sign.
    assign prod_fix = neg_q ? -acc : acc;
    assign q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; divide by zero skips the iterations entirely.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (op_div && b_zero) ? FIX : RUN;
            RUN:     if (count == CW'(WIDTH - 1)) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture on acceptance and one datapath iteration per RUN cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            acc      <= '0;
            opnd     <= '0;
            a_raw    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                count    <= '0;
                a_raw    <= a;
                is_div   <= op_div;
                neg_q    <= sa ^ sb;
                neg_r    <= sa;
                div_zero <= op_div && b_zero;
                if (op_div) begin
                    acc  <= {{WIDTH{1'b0}}, a_abs};
                    opnd <= b_abs;
                end else begin
                    acc  <= {{WIDTH{1'b0}}, b_abs};
                    opnd <= a_abs;
                end
            end
        end else if (state == RUN) begin
            acc   <= acc_step;
            count <= count + 1'b1;
        end
    end

    // HI/LO: written only at FIX, or by MTHI/MTLO while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            if (div_zero) begin
                hi <= a_raw;
                lo <= '1;
            end else if (is_div) begin
                hi <= r_fix;
                lo <= q_fix;
            end else begin
                {hi, lo} <= prod_fix;
            end
        end else if (state == IDLE) begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
        end
    end

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed table, corner sequences, random ops.
module tb_mips_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, wr_hi, wr_lo;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mips_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] mh, output logic [31:0] ml);
        logic [63:0] p;
        longint      sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: p = 64'(sx * sy);
            2'd1: p = {32'b0, x} * {32'b0, y};
            2'd2: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else        p = {x % y, x / y};
            end
        endcase
        mh = p[63:32];
        ml = p[31:0];
    endfunction

    // Cycles are counted from the one following the start edge (k=1).
    task automatic wait_done(output int lat);
        logic [31:0] h0, l0;
        logic        stable, busy_ok, seen;
        lat = -1; stable = 1'b1; busy_ok = 1'b1; seen = 1'b0;
        h0 = '0; l0 = '0;
        for (int k = 1; k <= 100 && !seen; k++) begin
            @(negedge clk);
            start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
            if (k == 1) begin h0 = hi; l0 = lo; end
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end else if (hi !== h0 || lo !== l0) begin
                stable = 1'b0;
            end
        end
        check("done_seen", 64'(seen), 64'd1);
        check("busy_until_done", 64'(busy_ok), 64'd1);
        check("hilo_held_during_op", 64'(stable), 64'd1);
        @(negedge clk);
        check("idle_after_done", 64'({busy, done}), 64'd0);
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        wait_done(lat);
    endtask

    initial begin
        int          lat, pulses;
        logic [31:0] mh, ml, exp_hi, exp_lo;

        tbl[0] = '{op: 2'd1, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, hi: 32'hFFFF_FFFE, lo: 32'h0000_0001, lat: 34};
        tbl[1] = '{op: 2'd0, a: 32'hFFFF_FFFD, b: 32'd7,         hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, lat: 34};
        tbl[2] = '{op: 2'd2, a: 32'hFFFF_FFF9, b: 32'd2,         hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFD, lat: 34};
        tbl[3] = '{op: 2'd3, a: 32'd100,       b: 32'd0,         hi: 32'd100,       lo: 32'hFFFF_FFFF, lat: 2};
        tbl[4] = '{op: 2'd2, a: 32'h8000_0000, b: 32'hFFFF_FFFF, hi: 32'h0,         lo: 32'h8000_0000, lat: 34};
        tbl[5] = '{op: 2'd3, a: 32'd100,       b: 32'd7,         hi: 32'd2,         lo: 32'd14,        lat: 34};
        tbl[6] = '{op: 2'd2, a: 32'hFFFF_FFF9, b: 32'd0,         hi: 32'hFFFF_FFF9, lo: 32'hFFFF_FFFF, lat: 2};
        tbl[7] = '{op: 2'd0, a: 32'h8000_0000, b: 32'h8000_0000, hi: 32'h4000_0000, lo: 32'h0,         lat: 34};
        tbl[8] = '{op: 2'd2, a: 32'd7,         b: 32'hFFFF_FFFE, hi: 32'd1,         lo: 32'hFFFF_FFFD, lat: 34};

        reset = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        op = '0; a = '0; b = '0; wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        reset = 1'b0;

        // MTLO / MTHI while idle
        @(negedge clk); wr_lo = 1'b1; wdata = 32'h1234;
        @(negedge clk); wr_lo = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h1234);
        check("mtlo_hi_untouched", 64'(hi), 64'd0);
        wr_hi = 1'b1; wdata = 32'hCAFE;
        @(negedge clk); wr_hi = 1'b0;
        check("mthi_hi", 64'(hi), 64'hCAFE);

        // MTLO in the same cycle as start: write lands, then the result overwrites it
        op = 2'd1; a = 32'd3; b = 32'd4; start = 1'b1; wr_lo = 1'b1; wdata = 32'h5555;
        @(negedge clk); start = 1'b0; wr_lo = 1'b0;
        check("mtlo_with_start_lo", 64'(lo), 64'h5555);
        check("mtlo_with_start_busy", 64'(busy), 64'd1);
        wait_done(lat);
        check("mtlo_with_start_result_hi", 64'(hi), 64'd0);
        check("mtlo_with_start_result_lo", 64'(lo), 64'd12);

        // Directed table
        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, lat);
            check($sformatf("tbl%0d_hi", i), 64'(hi), 64'(tbl[i].hi));
            check($sformatf("tbl%0d_lo", i), 64'(lo), 64'(tbl[i].lo));
            check($sformatf("tbl%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
        end
        exp_hi = tbl[8].hi;

        // start held for 40 cycles; MTHI attempted while busy
        @(negedge clk); op = 2'd1; a = 32'd5; b = 32'd6; start = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 5) begin wr_hi = 1'b1; wdata = 32'hDEAD; end
            if (k == 6) begin
                wr_hi = 1'b0;
                check("wr_hi_while_busy", 64'(hi), 64'(exp_hi));
            end
            if (done) pulses++;
        end
        start = 1'b0;
        check("held_start_done_pulses", 64'(pulses), 64'd1);
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        check("held_start_settles_idle", 64'(busy), 64'd0);
        check("held_start_hi", 64'(hi), 64'd0);
        check("held_start_lo", 64'(lo), 64'd30);

        // Reset during RUN (count==10) abandons the operation
        @(negedge clk); op = 2'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_hi", 64'(hi), 64'd0);
        check("midreset_lo", 64'(lo), 64'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midreset_no_done", 64'(pulses), 64'd0);
        do_op(2'd3, 32'd100, 32'd7, lat);
        check("after_reset_hi", 64'(hi), 64'd2);
        check("after_reset_lo", 64'(lo), 64'd14);

        // Random operations against the arithmetic reference
        for (int n = 0; n < 500; n++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            int          sel;
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0)      rb = 32'd0;
            else if (sel == 1) rb = 32'hFFFF_FFFF;
            else if (sel == 2) rb = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 15) == 0) ra = 32'h8000_0000;
            model(ro, ra, rb, mh, ml);
            do_op(ro, ra, rb, lat);
            exp_hi = mh; exp_lo = ml;
            check($sformatf("rand%0d_op%0d_hi", n, ro), 64'(hi), 64'(exp_hi));
            check($sformatf("rand%0d_op%0d_lo", n, ro), 64'(lo), 64'(exp_lo));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
